// File: rtl/counter_pkg.sv
// counter_pkg: FSM state encoding and direction levels shared with up_down_counter
package counter_pkg;
    typedef enum logic [1:0] {
        S_UP    = 2'b00,
        S_DOWN  = 2'b01,
        S_PAUSE = 2'b10
    } state_t;
    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: synchronise, debounce and edge-detect one raw push-button
module btn_debounce #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic press
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES - 1);
    logic [SYNC_STAGES-1:0] sync;
    logic [CW-1:0] cnt;
    logic db_q;
    logic s;
    assign s = sync[SYNC_STAGES-1];
    assign press = level & ~db_q;
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            sync  <= '0;
            cnt   <= '0;
            level <= 1'b0;
            db_q  <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], raw};
            db_q <= level;
            if (s == level)
                cnt <= '0;
            else if (cnt == CMAX) begin
                level <= s;
                cnt   <= '0;
            end else
                cnt <= cnt + 1'b1;
        end
endmodule

// File: rtl/counter_dir_ctrl.sv
// counter_dir_ctrl: turns debounced up/down/pause presses into direction and enable levels
module counter_dir_ctrl
    import counter_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_pause,
    output logic       up_down,
    output logic       count_en,
    output logic       dir_changed,
    output logic [1:0] state
);
    logic [2:0] raw, pr, unused_level;
    state_t cur, nxt, resume;
    logic nud, legal;
    assign raw = {btn_pause, btn_down, btn_up};
    assign state = cur;
    for (genvar b = 0; b < 3; b++) begin : g_btn
        btn_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
            .clk(clk), .reset(reset), .raw(raw[b]), .level(unused_level[b]), .press(pr[b])
        );
    end
    // pause wins over everything; up+down together cancels out
    always_comb begin
        legal  = cur == S_UP || cur == S_DOWN || cur == S_PAUSE;
        resume = up_down ? S_UP : S_DOWN;
        nxt    = pr[2] ? (cur == S_PAUSE ? resume : S_PAUSE) :
                 (pr[0] & ~pr[1]) ? S_UP :
                 (pr[1] & ~pr[0]) ? S_DOWN :
                 legal ? cur : S_UP;
        nud    = nxt == S_UP ? DIR_UP : nxt == S_DOWN ? DIR_DOWN : up_down;
    end
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            cur         <= S_UP;
            up_down     <= DIR_UP;
            count_en    <= 1'b1;
            dir_changed <= 1'b0;
        end else begin
            cur         <= nxt;
            up_down     <= nud;
            count_en    <= nxt != S_PAUSE;
            dir_changed <= nud != up_down;
        end
endmodule

// File: tb/tb_counter_dir_ctrl.sv
// tb_counter_dir_ctrl: vector table, random presses against an event-level model, and latency/reset corner cases
module tb_counter_dir_ctrl;
    logic clk = 1'b0, reset = 1'b0;
    logic btn_up = 1'b0, btn_down = 1'b0, btn_pause = 1'b0;
    logic up_down, count_en, dir_changed;
    logic [1:0] state;
    int compared = 0, mismatched = 0, pulses = 0;
    logic prev_ud = 1'b1;

    counter_dir_ctrl dut (
        .clk(clk), .reset(reset), .btn_up(btn_up), .btn_down(btn_down), .btn_pause(btn_pause),
        .up_down(up_down), .count_en(count_en), .dir_changed(dir_changed), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic u, d, p;
        int hold;
        logic ud, en;
        logic [1:0] st;
    } vec_t;

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got ud/en/st=%b want %b", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %b want %b", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic u, input logic d, input logic p, input int hold);
        btn_up = u; btn_down = d; btn_pause = p;
        cyc(hold);
        btn_up = 0; btn_down = 0; btn_pause = 0;
        cyc(14);
    endtask

    // dir_changed must pulse exactly when up_down toggles
    always @(negedge clk) begin
        if (reset) begin
            compared++;
            if (dir_changed !== (up_down != prev_ud)) begin
                mismatched++;
                $display("FAIL dir_pulse: dir_changed=%b ud %b->%b", dir_changed, prev_ud, up_down);
            end
            pulses += int'(dir_changed);
        end
        prev_ud = up_down;
    end

    vec_t tbl[13];
    int mst, mud, mchg, p0;
    logic u, d, p;
    int dur;

    initial begin
        tbl[0]  = '{0, 1, 0, 10, 0, 1, 2'b01};
        tbl[1]  = '{1, 0, 0, 3,  0, 1, 2'b01};
        tbl[2]  = '{0, 0, 1, 6,  0, 0, 2'b10};
        tbl[3]  = '{0, 0, 1, 6,  0, 1, 2'b01};
        tbl[4]  = '{1, 0, 0, 4,  1, 1, 2'b00};
        tbl[5]  = '{1, 1, 0, 8,  1, 1, 2'b00};
        tbl[6]  = '{0, 1, 1, 6,  1, 0, 2'b10};
        tbl[7]  = '{0, 1, 0, 5,  0, 1, 2'b01};
        tbl[8]  = '{0, 0, 1, 5,  0, 0, 2'b10};
        tbl[9]  = '{1, 0, 0, 5,  1, 1, 2'b00};
        tbl[10] = '{0, 0, 1, 5,  1, 0, 2'b10};
        tbl[11] = '{1, 1, 0, 6,  1, 0, 2'b10};
        tbl[12] = '{0, 0, 1, 5,  1, 1, 2'b00};

        cyc(2);
        chk("reset_held", {up_down, count_en, state}, 4'b1100);
        reset = 1'b1;
        cyc(3);
        chk("after_release", {up_down, count_en, state}, 4'b1100);
        chk1("after_release_dc", dir_changed, 1'b0);

        btn_down = 1;
        cyc(6);
        chk("down_lat6", {up_down, count_en, state}, 4'b1100);
        cyc(1);
        chk("down_lat7", {up_down, count_en, state}, 4'b0101);
        chk1("down_lat7_dc", dir_changed, 1'b1);
        cyc(1);
        chk1("down_dc_once", dir_changed, 1'b0);
        cyc(2);
        chk("down_held", {up_down, count_en, state}, 4'b0101);
        btn_down = 0;
        cyc(14);
        @(posedge clk);
        #2 reset = 1'b0;
        #1 chk("async_reset", {up_down, count_en, state}, 4'b1100);
        chk1("async_reset_dc", dir_changed, 1'b0);
        cyc(2);
        reset = 1'b1;
        cyc(2);

        foreach (tbl[i]) begin
            press(tbl[i].u, tbl[i].d, tbl[i].p, tbl[i].hold);
            chk($sformatf("vec%0d", i), {up_down, count_en, state}, {tbl[i].ud, tbl[i].en, tbl[i].st});
        end

        mst = 0; mud = 1; mchg = 0; p0 = pulses;
        for (int i = 0; i < 60; i++) begin
            {p, d, u} = 3'($urandom_range(1, 7));
            dur = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 3)) : int'($urandom_range(4, 10));
            press(u, d, p, dur);
            if (dur >= 4) begin
                if (p) mst = (mst == 2) ? (mud ? 0 : 1) : 2;
                else if (u && !d) begin mst = 0; mchg += int'(mud != 1); mud = 1; end
                else if (d && !u) begin mst = 1; mchg += int'(mud != 0); mud = 0; end
            end
            chk($sformatf("rand%0d", i), {up_down, count_en, state}, {1'(mud), 1'(mst != 2), 2'(mst)});
        end
        compared++;
        if (pulses - p0 != mchg) begin
            mismatched++;
            $display("FAIL rand_pulse_count: got %0d want %0d", pulses - p0, mchg);
        end

        btn_down = 1;
        cyc(4);
        reset = 1'b0;
        #1 chk("mid_debounce_reset", {up_down, count_en, state}, 4'b1100);
        cyc(2);
        reset = 1'b1;
        cyc(6);
        chk("post_reset_lat6", {up_down, count_en, state}, 4'b1100);
        cyc(1);
        chk("post_reset_lat7", {up_down, count_en, state}, 4'b0101);
        btn_down = 0;
        cyc(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
